// File: rtl/irq_trap_controller.sv
// Machine-mode trap sequencer: arbitrates exceptions and masked IRQs into a 1-cycle trap pulse.
// Optional macro IRQ_EDGE_EN selects edge-captured pending IRQs instead of level mode.
module irq_trap_controller #(
  parameter int unsigned N_IRQ          = 16,
  parameter int unsigned IRQ_MIE_BASE   = 16,
  parameter int unsigned IRQ_CAUSE_BASE = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [31:0]      mie_i,
  input  logic             exception_i,
  input  logic [31:0]      exception_cause_i,
  input  logic             mret_i,
  output logic             trap_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] irq_ack_o,
  output logic             irq_ret_o,
  output logic             busy_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StEnter   = 2'd1;
  localparam logic [1:0] StHandler = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             trap_q, trap_d;
  logic [31:0]      mcause_q, mcause_d;
  logic [N_IRQ-1:0] ack_q, ack_d;
  logic             ret_q, ret_d;
  logic             busy_q, busy_d;

  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] eligible;
  logic [4:0]       win_idx;

  // Only the IRQ enable window of MIE matters here.
  logic unused_mie;
  assign unused_mie = ^mie_i;

`ifdef IRQ_EDGE_EN
  logic [N_IRQ-1:0] req_q;
  logic [N_IRQ-1:0] pending_q, pending_d;

  // A fresh rising edge beats the ack clearing the same bit.
  assign pending_d = (pending_q & ~ack_q) | (irq_req_i & ~req_q);
  assign pending   = pending_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_q     <= '0;
      pending_q <= '0;
    end else begin
      req_q     <= irq_req_i;
      pending_q <= pending_d;
    end
  end
`else
  assign pending = irq_req_i;
`endif

  assign eligible = pending & mie_i[IRQ_MIE_BASE +: N_IRQ];

  always_comb begin
    win_idx = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = 5'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    trap_d   = 1'b0;
    mcause_d = mcause_q;
    ack_d    = '0;
    ret_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (exception_i) begin
          state_d  = StEnter;
          trap_d   = 1'b1;
          mcause_d = exception_cause_i;
        end else if (|eligible) begin
          state_d  = StEnter;
          trap_d   = 1'b1;
          mcause_d = {1'b1, 31'(IRQ_CAUSE_BASE + 32'(win_idx))};
          ack_d    = N_IRQ'(1) << win_idx;
        end
      end
      StEnter: state_d = StHandler;
      StHandler: begin
        // A nested exception outranks a simultaneous mret.
        if (exception_i) begin
          state_d  = StEnter;
          trap_d   = 1'b1;
          mcause_d = exception_cause_i;
        end else if (mret_i) begin
          state_d = StIdle;
          ret_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      trap_q   <= 1'b0;
      mcause_q <= '0;
      ack_q    <= '0;
      ret_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      trap_q   <= trap_d;
      mcause_q <= mcause_d;
      ack_q    <= ack_d;
      ret_q    <= ret_d;
      busy_q   <= busy_d;
    end
  end

  assign trap_o    = trap_q;
  assign mcause_o  = mcause_q;
  assign irq_ack_o = ack_q;
  assign irq_ret_o = ret_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_irq_trap_controller.sv
// Table-driven bench for irq_trap_controller plus hand sequences for masking and pulse capture.
module tb_irq_trap_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] irq;
  logic [31:0] mie;
  logic        exc;
  logic [31:0] cause;
  logic        mret;
  logic        trap;
  logic [31:0] mcause;
  logic [15:0] ack;
  logic        ret;
  logic        busy;

  int total = 0;
  int bad   = 0;

  irq_trap_controller #(
    .N_IRQ(16),
    .IRQ_MIE_BASE(16),
    .IRQ_CAUSE_BASE(16)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .irq_req_i(irq),
    .mie_i(mie),
    .exception_i(exc),
    .exception_cause_i(cause),
    .mret_i(mret),
    .trap_o(trap),
    .mcause_o(mcause),
    .irq_ack_o(ack),
    .irq_ret_o(ret),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [15:0] irq;
    logic [31:0] mie;
    logic        exc;
    logic [31:0] cause;
    logic        mret;
    logic        e_trap;
    logic [31:0] e_mc;
    logic [15:0] e_ack;
    logic        e_ret;
    logic        e_busy;
  } vec_t;

  vec_t vecs[27];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] i, input logic [31:0] m, input logic e,
                      input logic [31:0] c, input logic mr);
    rst_n = r; irq = i; mie = m; exc = e; cause = c; mret = mr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; mie = '0; exc = 1'b0; cause = '0; mret = 1'b0;
    step(1'b0, 16'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 16'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("reset_trap", {31'b0, trap}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_mcause", mcause, 32'h0);

`ifndef IRQ_EDGE_EN
    // Single IRQ entry and return
    vecs[0]  = '{1'b0, 16'h0000, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'h0001, 32'h0001_0000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0010, 16'h0001, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 16'h0000, 32'h0001_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 16'h0001, 32'h0001_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 16'h0000, 32'h0001_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 16'h0000, 32'h0001_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0};
    // Exception beats IRQs, then lowest IRQ index wins
    vecs[7]  = '{1'b1, 16'h0028, 32'h0028_0000, 1'b1, 32'h2, 1'b0, 1'b1, 32'h0000_0002, 16'h0000, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 16'h0028, 32'h0028_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 16'h0028, 32'h0028_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 16'h0028, 32'h0028_0000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0013, 16'h0008, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 16'h0020, 32'h0028_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 16'h0020, 32'h0028_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 16'h0000, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 16'h0020, 32'h0028_0000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0015, 16'h0020, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 16'h0000, 32'h0028_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b1};
    vecs[15] = '{1'b1, 16'h0000, 32'h0028_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 16'h0000, 1'b1, 1'b0};
    // Masked IRQ, then MIE enables it; latched winner survives MIE clearing
    vecs[16] = '{1'b1, 16'h0010, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 16'h0010, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 16'h0010, 32'h0010_0000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0014, 16'h0010, 1'b0, 1'b1};
    vecs[19] = '{1'b1, 16'h0000, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b1};
    // Nested exception together with mret
    vecs[20] = '{1'b1, 16'h0000, 32'h0000_0000, 1'b1, 32'h7, 1'b1, 1'b1, 32'h0000_0007, 16'h0000, 1'b0, 1'b1};
    vecs[21] = '{1'b1, 16'h0000, 32'h0000_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b1};
    vecs[22] = '{1'b1, 16'h0000, 32'h0000_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 16'h0000, 1'b1, 1'b0};
    // Reset in the handler aborts without a return pulse
    vecs[23] = '{1'b1, 16'h0001, 32'h0001_0000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0010, 16'h0001, 1'b0, 1'b1};
    vecs[24] = '{1'b1, 16'h0000, 32'h0001_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b1};
    vecs[25] = '{1'b0, 16'h0000, 32'h0001_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0};
    vecs[26] = '{1'b1, 16'h0000, 32'h0001_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 16'h0000, 1'b0, 1'b0};

    foreach (vecs[k]) begin
      step(vecs[k].rst_n, vecs[k].irq, vecs[k].mie, vecs[k].exc, vecs[k].cause, vecs[k].mret);
      chk($sformatf("v%0d_trap", k), {31'b0, trap}, {31'b0, vecs[k].e_trap});
      chk($sformatf("v%0d_ack", k), {16'b0, ack}, {16'b0, vecs[k].e_ack});
      chk($sformatf("v%0d_ret", k), {31'b0, ret}, {31'b0, vecs[k].e_ret});
      chk($sformatf("v%0d_busy", k), {31'b0, busy}, {31'b0, vecs[k].e_busy});
      if (vecs[k].e_trap || !vecs[k].rst_n) chk($sformatf("v%0d_mcause", k), mcause, vecs[k].e_mc);
    end
`endif

    // Masked request held for 10 cycles must never trap
    begin
      int seen = 0;
      for (int c = 0; c < 10; c++) begin
        step(1'b1, 16'h0010, 32'h0, 1'b0, 32'h0, 1'b0);
        if (trap) seen++;
      end
      chk("masked_no_trap", 32'(seen), 32'h0);
      seen = 0;
      for (int c = 0; c < 4 && seen == 0; c++) begin
        step(1'b1, 16'h0010, 32'h0010_0000, 1'b0, 32'h0, 1'b0);
        if (trap) begin
          seen = 1;
          chk("unmask_mcause", mcause, 32'h8000_0014);
          chk("unmask_ack", {16'b0, ack}, 32'h0000_0010);
        end
      end
      chk("unmask_trap_seen", 32'(seen), 32'h1);
      step(1'b1, 16'h0, 32'h0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 16'h0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("unmask_ret", {31'b0, ret}, 32'h1);
    end

    // One-cycle IRQ pulse during the handler
    begin
      int seen = 0;
      step(1'b1, 16'h0, 32'h0004_0000, 1'b1, 32'h3, 1'b0);
      chk("pulse_enter_mcause", mcause, 32'h3);
      step(1'b1, 16'h0, 32'h0004_0000, 1'b0, 32'h0, 1'b0);
      step(1'b1, 16'h0004, 32'h0004_0000, 1'b0, 32'h0, 1'b0);
      chk("pulse_masked_in_handler", {31'b0, trap}, 32'h0);
      step(1'b1, 16'h0, 32'h0004_0000, 1'b0, 32'h0, 1'b0);
      step(1'b1, 16'h0, 32'h0004_0000, 1'b0, 32'h0, 1'b1);
      chk("pulse_ret", {31'b0, ret}, 32'h1);
      for (int c = 0; c < 4 && seen == 0; c++) begin
        step(1'b1, 16'h0, 32'h0004_0000, 1'b0, 32'h0, 1'b0);
        if (trap) begin
          seen = 1;
          chk("pulse_mcause", mcause, 32'h8000_0012);
        end
      end
`ifdef IRQ_EDGE_EN
      chk("pulse_kept", 32'(seen), 32'h1);
`else
      chk("pulse_lost", 32'(seen), 32'h0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
